// File: rtl/bcd_display_scanner_if.sv
// Handshake bundle carrying packed BCD words into the display scanner.
// valid/ready: a word moves on every rising clk edge where bcd_valid and
// bcd_ready are both 1; the source holds bcd_data stable while bcd_valid=1
// and bcd_ready=0, and may keep bcd_valid high indefinitely.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    bcd_valid;
  logic                    bcd_ready;
  logic [4*NUM_DIGITS-1:0] bcd_data;

  modport master (output bcd_valid, output bcd_data, input bcd_ready);
  modport slave  (input bcd_valid, input bcd_data, output bcd_ready);
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-segment 7-segment driver for a packed BCD word.
// Incoming words land in a shadow register and are committed to the display
// register only at a frame boundary (or while the scan is disabled), so a
// frame never shows a mix of old and new digits.
module bcd_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  en,
  input  logic                  blank_lz,
  bcd_display_scanner_if.slave  bus,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    pending;

  logic                    transfer;
  logic                    frame_end;
  logic                    commit;
  logic [3:0]              digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_run;
  logic [6:0]              seg_next;

  // Segment pattern (g..a) for one BCD digit; codes A-F show a dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h40;
    endcase
  endfunction

  // Only one word can wait in the shadow register; ready drops while it is full.
  assign bus.bcd_ready = !pending;
  assign transfer      = bus.bcd_valid && !pending;
  assign frame_end     = (cnt == CNT_MAX) && (idx == IDX_MAX);
  // A transfer needs pending=0 and a commit needs pending=1, so they never collide.
  assign commit        = pending && (!en || frame_end);

  // Shadow capture on transfer, shadow-to-display copy on commit.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (transfer) begin
      shadow  <= bus.bcd_data;
      pending <= 1'b1;
    end else if (commit) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  end

  // Dwell counter and digit index; held at digit 0 while the scan is disabled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
      idx <= '0;
    end else if (!en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Unpack digits and mark digits that sit inside the run of leading zeros.
  always_comb begin
    zero_run = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digits[k] = disp[4*k +: 4];
    end
    zero_run[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_run[k] = (digits[k] == 4'd0) && zero_run[k+1];
    end
  end

  // Segment value for the digit currently selected; digit 0 is never blanked.
  always_comb begin
    seg_next = seg_pattern(digits[idx]);
    if (blank_lz && (idx != '0) && zero_run[idx]) begin
      seg_next = 7'h00;
    end
  end

  // Registered display drive; dark whenever the scan is disabled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      seg <= '0;
      an  <= '0;
    end else if (!en) begin
      seg <= '0;
      an  <= '0;
    end else begin
      seg <= seg_next;
      an  <= NUM_DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: a cycle-level reference model predicts
// {bcd_ready, an, seg} after every clock edge into a queue and a monitor
// compares the DUT against it on the falling edge.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int RC = 4;
  localparam int DW = 4 * ND;
  localparam int W  = 1 + ND + 7;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          en = 1'b0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus_if ();

  bcd_display_scanner #(
    .NUM_DIGITS    (ND),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (en),
    .blank_lz(blank_lz),
    .bus     (bus_if),
    .seg     (seg),
    .an      (an)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]    seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic          m_pending = 1'b0;
  logic [DW-1:0] m_shadow  = '0;
  logic [DW-1:0] m_value   = '0;
  int            m_pos     = 0;   // cycles since the current frame began

  always @(posedge clk or negedge aresetn) begin
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic [DW-1:0] upper;
    logic [3:0]    dv;
    int            d;
    if (!aresetn) begin
      m_pending = 1'b0;
      m_shadow  = '0;
      m_value   = '0;
      m_pos     = 0;
      if (clk) exp_q.push_back({1'b1, {ND{1'b0}}, 7'h00});
    end else begin
      e_an  = '0;
      e_seg = 7'h00;
      if (en) begin
        d        = m_pos / RC;
        e_an[d]  = 1'b1;
        upper    = m_value >> (4 * d);
        dv       = upper[3:0];
        if (blank_lz && d > 0 && upper == '0) e_seg = 7'h00;
        else if (dv > 4'd9)                   e_seg = 7'h40;
        else                                  e_seg = seg_tbl[dv];
      end
      if (bus_if.bcd_valid && !m_pending) begin
        m_shadow  = bus_if.bcd_data;
        m_pending = 1'b1;
      end else if (m_pending && (!en || m_pos == ND * RC - 1)) begin
        m_value   = m_shadow;
        m_pending = 1'b0;
      end
      m_pos = en ? (m_pos + 1) % (ND * RC) : 0;
      exp_q.push_back({!m_pending, e_an, e_seg});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {bus_if.bcd_ready, an, seg};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL scan t=%0t got rdy=%b an=%b seg=%h exp rdy=%b an=%b seg=%h",
                 $time, got_v[W-1], got_v[W-2 -: ND], got_v[6:0],
                 exp_v[W-1], exp_v[W-2 -: ND], exp_v[6:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic rdy;
    int   n;
    n = 0;
    bus_if.bcd_valid = 1'b1;
    bus_if.bcd_data  = d;
    do begin
      @(negedge clk);
      rdy = bus_if.bcd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    bus_if.bcd_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h got ready=0 after %0d cycles, need ready=1", d, n);
    end
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (seg !== 7'h00 || an !== '0 || bus_if.bcd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s got seg=%h an=%b rdy=%b, need seg=00 an=0000 rdy=1",
               name, seg, an, bus_if.bcd_ready);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int nd;
    bus_if.bcd_valid = 1'b0;
    bus_if.bcd_data  = '0;

    idle(3);
    check_reset("reset_state");
    aresetn = 1'b1;

    // idle scan of an empty display
    en = 1'b1;
    idle(40);

    // load while dark, then scan 1234
    en = 1'b0;
    idle(2);
    send(16'h1234);
    idle(3);
    en = 1'b1;
    idle(22);

    // load mid-frame: must wait for the frame boundary
    send(16'h5678);
    idle(40);

    // leading-zero blanking
    blank_lz = 1'b1;
    en = 1'b0;
    send(16'h0070);
    idle(1);
    en = 1'b1;
    idle(20);
    en = 1'b0;
    send(16'h0000);
    idle(1);
    en = 1'b1;
    idle(20);

    // invalid digit, without and with blanking
    blank_lz = 1'b0;
    en = 1'b0;
    send(16'h0A09);
    en = 1'b1;
    idle(20);
    blank_lz = 1'b1;
    idle(20);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      blank_lz = $urandom_range(0, 1);
      nd = $urandom_range(0, ND);
      d  = '0;
      for (int k = 0; k < nd; k++) begin
        d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      send(d);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
    end

    // asynchronous reset mid-dwell with a word pending
    en = 1'b1;
    blank_lz = 1'b0;
    idle(9);
    send(16'h4321);
    @(negedge clk);
    #1;
    aresetn = 1'b0;
    #1;
    check_reset("async_reset");
    idle(3);
    aresetn = 1'b1;
    idle(24);
    en = 1'b0;
    idle(3);

    checks++;
    if (checks < 300) begin
      errors++;
      $display("FAIL coverage got %0d checks, need at least 300", checks);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
